// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer code conversions, the default depth,
// and the read-side status flag bundle.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int FIFO_DEPTH   = 2 ** ADDRSIZE_DEF;

  // Widest pointer the helper functions handle; callers zero-extend and slice.
  localparam int PTR_MAXW = 32;
  typedef logic [PTR_MAXW-1:0] ptr_word_t;

  // Registered read-side status flags, kept together so they update as one.
  typedef struct packed {
    logic empty;
    logic one_left;
    logic almost_empty;
    logic underflow;
  } rstat_t;

  // Binary to Gray. With zero upper bits the low W bits are the W-bit Gray
  // code, so one function serves every pointer width.
  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary. Each bit is the XOR of itself and all higher Gray bits;
  // zero upper bits leave the result width-independent.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = '0;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Pure combinational Gray-to-binary converter, shared with the write side.
module gray2bin_comb #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the reduction XOR of the Gray bits at and above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer and status block for the async FIFO. Holds the binary
// and Gray read pointers, drives the RAM read address, and registers empty,
// one-left, almost-empty, fill level and a sticky underflow flag, all computed
// from the post-read pointer against the synchronised write pointer.
module rptr_empty_lvl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE   = 4,
  parameter int AEMPTY_RST = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   raempty_thr,
  input  logic                raempty_ld,
  input  logic                rerr_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                rone_left,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] lvl_q,  lvl_d;
  logic [ADDRSIZE:0] thr_q,  thr_d;
  logic [ADDRSIZE:0] wbin_s;
  rstat_t            stat_q, stat_d;
  logic              rd_en;

  // Synchronised write pointer back to binary for level arithmetic.
  gray2bin_comb #(.W(PW)) u_wptr_g2b (
    .gray_i (rq2_wptr),
    .bin_o  (wbin_s)
  );

  // Next pointer, level and flags. Everything is derived from the post-read
  // pointer so the flags never claim data that a same-cycle read consumed.
  // Level is unsigned modulo 2**PW, so it stays correct across pointer wrap.
  // A freshly loaded threshold takes effect on its own load edge; thresholds
  // above the depth need no clamp since the level can never exceed them.
  always_comb begin
    rd_en                = rinc & ~stat_q.empty;
    rbin_d               = rbin_q + {{ADDRSIZE{1'b0}}, rd_en};
    rptr_d               = (rbin_d >> 1) ^ rbin_d;
    lvl_d                = wbin_s - rbin_d;
    thr_d                = raempty_ld ? raempty_thr : thr_q;
    stat_d               = stat_q;
    stat_d.empty         = (rptr_d == rq2_wptr);
    stat_d.one_left      = (lvl_d == PW'(1));
    stat_d.almost_empty  = (lvl_d <= thr_d);
    // Set dominates clear so a same-edge underflow is never lost.
    stat_d.underflow     = (rinc & stat_q.empty) | (stat_q.underflow & ~rerr_clr);
  end

  // State registers; reset leaves the FIFO empty with the default threshold.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q              <= '0;
      rptr_q              <= '0;
      lvl_q               <= '0;
      thr_q               <= PW'(AEMPTY_RST);
      stat_q.empty        <= 1'b1;
      stat_q.one_left     <= 1'b0;
      stat_q.almost_empty <= 1'b1;
      stat_q.underflow    <= 1'b0;
    end else begin
      rbin_q <= rbin_d;
      rptr_q <= rptr_d;
      lvl_q  <= lvl_d;
      thr_q  <= thr_d;
      stat_q <= stat_d;
    end
  end

  assign raddr         = rbin_q[ADDRSIZE-1:0];
  assign rptr          = rptr_q;
  assign rlevel        = lvl_q;
  assign rempty        = stat_q.empty;
  assign rone_left     = stat_q.one_left;
  assign ralmost_empty = stat_q.almost_empty;
  assign runderflow    = stat_q.underflow;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl (ADDRSIZE=4, AEMPTY_RST=2): a vector
// table for the single-step behaviour, then wrap, underflow and async-reset
// sequences.
module tb_rptr_empty_lvl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] rq2_wptr;
  logic [4:0] raempty_thr;
  logic       raempty_ld;
  logic       rerr_clr;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty, rone_left, ralmost_empty, runderflow;
  logic [4:0] rlevel;

  int n_pass = 0;
  int n_total = 0;

  rptr_empty_lvl #(.ADDRSIZE(4), .AEMPTY_RST(2)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .raempty_thr   (raempty_thr),
    .raempty_ld    (raempty_ld),
    .rerr_clr      (rerr_clr),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .rone_left     (rone_left),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic rinc; logic clr; logic ld; int thr; int wbin;
    int lvl; logic empty; logic one; logic ae; logic uf; int rbin;
  } vec_t;

  vec_t tv[14];

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input logic ri, input logic clr, input logic ld,
                      input logic [4:0] thr, input logic [4:0] wbin);
    @(negedge rclk);
    rinc = ri; rerr_clr = clr; raempty_ld = ld; raempty_thr = thr;
    rq2_wptr = g5(wbin);
    @(posedge rclk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rempty"}, rempty, 1);
    chk({tag, "_rone_left"}, rone_left, 0);
    chk({tag, "_ralmost_empty"}, ralmost_empty, 1);
    chk({tag, "_rlevel"}, rlevel, 0);
    chk({tag, "_rptr"}, rptr, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_runderflow"}, runderflow, 0);
  endtask

  initial begin
    logic [4:0] w_m, r_m, l_m;
    logic       e_m;
    logic [31:0] visited;
    int wraps;

    // rinc clr ld thr wbin | lvl empty one ae uf rbin
    tv[0]  = '{0,0,0, 0,3, 3,0,0,0,0,0};  // write of 3 becomes visible
    tv[1]  = '{1,0,0, 0,3, 2,0,0,1,0,1};  // first read, at threshold
    tv[2]  = '{1,0,0, 0,3, 1,0,1,1,0,2};  // one left
    tv[3]  = '{0,0,1, 0,3, 1,0,1,0,0,2};  // thr=0 applies on load edge
    tv[4]  = '{1,0,0, 0,3, 0,1,0,1,0,3};  // drained
    tv[5]  = '{1,0,0, 0,3, 0,1,0,1,1,3};  // underflow, pointer holds
    tv[6]  = '{0,0,0, 0,3, 0,1,0,1,1,3};  // sticky
    tv[7]  = '{1,1,0, 0,3, 0,1,0,1,1,3};  // set beats clear
    tv[8]  = '{0,1,0, 0,3, 0,1,0,1,0,3};  // clear alone
    tv[9]  = '{0,0,0, 0,8, 5,0,0,0,0,3};  // five more visible
    tv[10] = '{0,0,1,31,8, 5,0,0,1,0,3};  // oversized threshold
    tv[11] = '{1,0,1, 5,8, 4,0,0,1,0,4};  // read with new thr=5
    tv[12] = '{1,0,0, 0,9, 4,0,0,1,0,5};  // read + write: level holds
    tv[13] = '{0,0,1, 3,9, 4,0,0,0,0,5};  // thr=3, level 4 above it

    rrst_n = 1'b0; rinc = 0; rerr_clr = 0; raempty_ld = 0;
    raempty_thr = '0; rq2_wptr = '0;
    #12;
    chk_reset("rst");
    @(negedge rclk);
    rrst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tv[i].rinc, tv[i].clr, tv[i].ld, 5'(tv[i].thr), 5'(tv[i].wbin));
      chk($sformatf("v%0d_rlevel", i), rlevel, tv[i].lvl);
      chk($sformatf("v%0d_rempty", i), rempty, tv[i].empty);
      chk($sformatf("v%0d_rone_left", i), rone_left, tv[i].one);
      chk($sformatf("v%0d_ralmost_empty", i), ralmost_empty, tv[i].ae);
      chk($sformatf("v%0d_runderflow", i), runderflow, tv[i].uf);
      chk($sformatf("v%0d_raddr", i), raddr, tv[i].rbin % 16);
      chk($sformatf("v%0d_rptr", i), rptr, g5(5'(tv[i].rbin)));
    end

    // Continuous reads while the write pointer advances past the 32 wrap.
    w_m = 5'd9; r_m = 5'd5; l_m = 5'd4; e_m = 1'b0;
    visited = '0; wraps = 0;
    for (int k = 0; k < 56; k++) begin
      if (k < 40) w_m = w_m + 5'd1;
      step(1'b1, 1'b0, 1'b0, 5'd0, w_m);
      if (!e_m) r_m = r_m + 5'd1;
      l_m = w_m - r_m;
      e_m = (l_m == 5'd0);
      if (rptr == 5'd0 && r_m == 5'd0) wraps++;
      visited[rptr] = 1'b1;
      chk($sformatf("w%0d_rlevel", k), rlevel, l_m);
      chk($sformatf("w%0d_rempty", k), rempty, e_m);
      chk($sformatf("w%0d_rptr", k), rptr, g5(r_m));
      chk($sformatf("w%0d_ralmost_empty", k), ralmost_empty, l_m <= 5'd3);
      chk($sformatf("w%0d_empty_vs_level", k), rempty, rlevel == 5'd0);
      chk($sformatf("w%0d_level_le_depth", k), rlevel <= 5'd16, 1);
    end
    chk("wrap_all_rptr_visited", visited == 32'hFFFF_FFFF, 1);
    chk("wrap_rptr_returned_to_0", wraps >= 1, 1);
    chk("wrap_underflow_after_drain", runderflow, 1);

    // Asynchronous reset in the middle of a drain at level 5.
    @(negedge rclk);
    rrst_n = 1'b0; rinc = 0; rq2_wptr = '0;
    #2;
    @(negedge rclk);
    rrst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd5);
    chk("pre_rst_rlevel", rlevel, 5);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd5);
    chk("pre_rst_rlevel2", rlevel, 4);
    #2;
    rrst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    rq2_wptr = '0; rinc = 0;
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;
    chk("post_rst_rempty", rempty, 1);
    chk("post_rst_rlevel", rlevel, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
